collision_detector: RTL and testbench

COLLISION_DETECTOR -- requirements
Module: collision_detector

---
 rtl/collision_detector.sv | 121 ++++++++++++
 tb/tb_collision_detector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_detector.sv
// Maze collision detector: looks up pacman's new tile in the maze ROM, reports one
// collision event per accepted move and tracks which pills have been eaten.
module collision_detector #(
    parameter int unsigned TOTAL_PILLS = 244,
    parameter logic [3:0]  GHOST_CODE  = 4'b1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pos_valid,
    input  logic [4:0] pac_x,
    input  logic [4:0] pac_y,
    input  logic [4:0] ghost_x,
    input  logic [4:0] ghost_y,
    output logic       busy,
    output logic       rom_rd,
    output logic [9:0] rom_addr,
    input  logic [1:0] rom_data,
    output logic [3:0] collision_type,
    output logic [9:0] pills_left,
    output logic       all_eaten
);

    localparam logic [9:0] PILLS_INIT = 10'(TOTAL_PILLS);

    localparam logic [1:0] CELL_WALL  = 2'b01;
    localparam logic [1:0] CELL_PILL  = 2'b10;
    localparam logic [1:0] CELL_POWER = 2'b11;

    localparam logic [3:0] CODE_NONE  = 4'b0000;
    localparam logic [3:0] CODE_WALL  = 4'b0001;
    localparam logic [3:0] CODE_PILL  = 4'b0010;
    localparam logic [3:0] CODE_POWER = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EVAL,
        REPORT
    } state_t;

    state_t state, state_nx;

    logic [4:0]    lat_px, lat_py, lat_gx, lat_gy;
    logic [1023:0] eaten;
    logic [9:0]    tile;
    logic [3:0]    code;
    logic          eat;

    assign tile = {lat_py, lat_px};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pos_valid) state_nx = READ;
            READ:    state_nx = EVAL;
            EVAL:    state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Ghost outranks everything, so a ghost on a pill leaves the pill uneaten.
    always_comb begin
        code = CODE_NONE;
        eat  = 1'b0;
        if ((lat_px == lat_gx) && (lat_py == lat_gy)) begin
            code = GHOST_CODE;
        end else if (rom_data == CELL_WALL) begin
            code = CODE_WALL;
        end else if (!eaten[tile]) begin
            if (rom_data == CELL_PILL) begin
                code = CODE_PILL;
                eat  = 1'b1;
            end else if (rom_data == CELL_POWER) begin
                code = CODE_POWER;
                eat  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy           <= 1'b0;
            rom_rd         <= 1'b0;
            rom_addr       <= '0;
            collision_type <= '0;
            pills_left     <= PILLS_INIT;
            all_eaten      <= 1'b0;
            eaten          <= '0;
            lat_px         <= '0;
            lat_py         <= '0;
            lat_gx         <= '0;
            lat_gy         <= '0;
        end else begin
            busy           <= (state_nx != IDLE);
            rom_rd         <= (state == IDLE) && pos_valid;
            collision_type <= (state == EVAL) ? code : CODE_NONE;
            all_eaten      <= all_eaten || (pills_left == '0);
            if ((state == IDLE) && pos_valid) begin
                lat_px   <= pac_x;
                lat_py   <= pac_y;
                lat_gx   <= ghost_x;
                lat_gy   <= ghost_y;
                rom_addr <= {pac_y, pac_x};
            end
            if ((state == EVAL) && eat) begin
                eaten[tile] <= 1'b1;
                if (pills_left != '0) pills_left <= pills_left - 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench: two detectors (default pill count and a count of 2) share one
// stimulus stream and a randomised maze ROM; expectations come from a tile-level model.
module tb_collision_detector;

    logic       clk;
    logic       reset;
    logic       pos_valid;
    logic [4:0] pac_x, pac_y, ghost_x, ghost_y;
    logic [1:0] rom_data;

    logic       busy1, rom_rd1, all_eaten1;
    logic [9:0] rom_addr1, pills_left1;
    logic [3:0] ct1;
    logic       busy2, rom_rd2, all_eaten2;
    logic [9:0] rom_addr2, pills_left2;
    logic [3:0] ct2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Behavioural model state
    logic [1:0] maze [1024];
    bit         eaten_m [1024];
    int         cnt1, cnt2;
    bit         ae1, ae2;

    collision_detector #(.TOTAL_PILLS(244), .GHOST_CODE(4'b1000)) dut1 (
        .clk(clk), .reset(reset), .pos_valid(pos_valid),
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .busy(busy1), .rom_rd(rom_rd1), .rom_addr(rom_addr1), .rom_data(rom_data),
        .collision_type(ct1), .pills_left(pills_left1), .all_eaten(all_eaten1)
    );

    collision_detector #(.TOTAL_PILLS(2), .GHOST_CODE(4'b1000)) dut2 (
        .clk(clk), .reset(reset), .pos_valid(pos_valid),
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .busy(busy2), .rom_rd(rom_rd2), .rom_addr(rom_addr2), .rom_data(rom_data),
        .collision_type(ct2), .pills_left(pills_left2), .all_eaten(all_eaten2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM answers one cycle after the strobe; outside that slot it returns noise.
    always @(posedge clk) begin
        if (rom_rd1) rom_data <= maze[rom_addr1];
        else         rom_data <= 2'($urandom_range(0, 3));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 1024; i++) eaten_m[i] = 1'b0;
        cnt1 = 244;
        cnt2 = 2;
        ae1  = 1'b0;
        ae2  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy1, 0);
        chk("rst_rom_rd", rom_rd1, 0);
        chk("rst_rom_addr", rom_addr1, 0);
        chk("rst_ct", ct1, 0);
        chk("rst_pills1", pills_left1, 244);
        chk("rst_pills2", pills_left2, 2);
        chk("rst_all_eaten1", all_eaten1, 0);
        chk("rst_all_eaten2", all_eaten2, 0);
    endtask

    // One accepted move; hold keeps pos_valid asserted while the lookup is busy.
    task automatic visit(input logic [4:0] px, input logic [4:0] py,
                         input logic [4:0] gx, input logic [4:0] gy, input bit hold);
        logic [9:0] a;
        logic [3:0] exp_code;
        int         old1;
        bit         old_ae2;
        a        = {py, px};
        old1     = cnt1;
        old_ae2  = ae2;
        exp_code = 4'b0000;
        if (px == gx && py == gy)                   exp_code = 4'b1000;
        else if (maze[a] == 2'b01)                  exp_code = 4'b0001;
        else if (maze[a] == 2'b10 && !eaten_m[a])   exp_code = 4'b0010;
        else if (maze[a] == 2'b11 && !eaten_m[a])   exp_code = 4'b0100;
        if (exp_code == 4'b0010 || exp_code == 4'b0100) begin
            eaten_m[a] = 1'b1;
            if (cnt1 > 0) cnt1--;
            if (cnt2 > 0) cnt2--;
        end

        @(negedge clk);
        pac_x = px; pac_y = py; ghost_x = gx; ghost_y = gy;
        pos_valid = 1'b1;

        @(negedge clk);
        chk("n1_rom_rd", rom_rd1, 1);
        chk("n1_rom_addr", rom_addr1, a);
        chk("n1_busy", busy1, 1);
        chk("n1_ct", ct1, 0);
        if (!hold) pos_valid = 1'b0;
        pac_x = 5'($urandom); pac_y = 5'($urandom);
        ghost_x = 5'($urandom); ghost_y = 5'($urandom);

        @(negedge clk);
        chk("n2_rom_rd", rom_rd1, 0);
        chk("n2_ct", ct1, 0);
        chk("n2_busy", busy1, 1);
        chk("n2_pills1", pills_left1, old1);

        @(negedge clk);
        chk("n3_ct1", ct1, exp_code);
        chk("n3_ct2", ct2, exp_code);
        chk("n3_rom_rd", rom_rd1, 0);
        chk("n3_busy", busy1, 1);
        chk("n3_pills1", pills_left1, cnt1);
        chk("n3_pills2", pills_left2, cnt2);
        chk("n3_all_eaten2", all_eaten2, old_ae2);

        @(negedge clk);
        pos_valid = 1'b0;
        ae1 = ae1 || (cnt1 == 0);
        ae2 = ae2 || (cnt2 == 0);
        chk("n4_ct", ct1, 0);
        chk("n4_busy", busy1, 0);
        chk("n4_rom_rd", rom_rd1, 0);
        chk("n4_all_eaten1", all_eaten1, ae1);
        chk("n4_all_eaten2", all_eaten2, ae2);
    endtask

    // Reset asserted during the evaluation cycle of a lookup.
    task automatic abort_visit(input logic [4:0] px, input logic [4:0] py);
        @(negedge clk);
        pac_x = px; pac_y = py; ghost_x = 5'd31; ghost_y = 5'd31;
        pos_valid = 1'b1;
        @(negedge clk);
        pos_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        reset_model();
        @(negedge clk);
        chk("abort_ct", ct1, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_pills1", pills_left1, 244);
        chk("abort_pills2", pills_left2, 2);
    endtask

    initial begin
        logic [4:0] rx, ry, gx, gy;
        reset = 1'b0;
        pos_valid = 1'b0;
        pac_x = '0; pac_y = '0; ghost_x = '0; ghost_y = '0;
        for (int i = 0; i < 1024; i++) maze[i] = 2'($urandom_range(0, 3));
        maze[{5'd5, 5'd3}] = 2'b10;
        maze[{5'd2, 5'd7}] = 2'b01;
        maze[{5'd4, 5'd9}] = 2'b11;
        maze[{5'd1, 5'd1}] = 2'b10;
        maze[{5'd6, 5'd6}] = 2'b10;
        reset_model();

        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;

        visit(5'd3, 5'd5, 5'd10, 5'd10, 1'b0);   // pill
        visit(5'd3, 5'd5, 5'd10, 5'd10, 1'b0);   // revisit, already eaten
        visit(5'd7, 5'd2, 5'd0, 5'd0, 1'b0);     // wall
        visit(5'd9, 5'd4, 5'd0, 5'd0, 1'b0);     // power pill
        visit(5'd1, 5'd1, 5'd1, 5'd1, 1'b0);     // ghost on pill
        visit(5'd1, 5'd1, 5'd2, 5'd2, 1'b0);     // same pill still uneaten
        visit(5'd6, 5'd6, 5'd0, 5'd0, 1'b1);     // pos_valid held while busy

        for (int n = 0; n < 60; n++) begin
            rx = 5'($urandom_range(0, 7));
            ry = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                gx = rx; gy = ry;
            end else begin
                gx = 5'($urandom); gy = 5'($urandom);
            end
            visit(rx, ry, gx, gy, ($urandom_range(0, 4) == 0));
        end

        abort_visit(5'd3, 5'd5);
        visit(5'd3, 5'd5, 5'd10, 5'd10, 1'b0);   // eaten bitmap cleared by reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
